i2c_master_arbiter: RTL and testbench

- Shares one I2C write master between NUM_REQ independent requesters.
- Grants one requester at a time using round-robin order and latches that requester's device address, register address and write data.
- Holds the master's enable high until the master's done pulse arrives or a watchdog expires, then acknowledges the requester.
- Sits between configuration clients (sensor and codec init logic) and the I2C master; the master's SCL/SDA pins are not touched.

---
 rtl/i2c_arb_pkg.sv | 15 +
 rtl/i2c_master_arbiter_rr_pick.sv | 28 ++
 rtl/i2c_master_arbiter.sv | 147 ++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared state encoding and operand widths for the I2C master arbiter.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    localparam int DEV_W = 7;
    localparam int REG_W = 8;
    localparam int DAT_W = 8;

endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
// Zero latency; no backpressure (pure function of its inputs).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               vld_o,
    output logic [IDW-1:0]     idx_o
);

    int cand;

    // Scan offsets from farthest to nearest so the nearest match is the last write.
    always_comb begin
        vld_o = |req_i;
        idx_o = '0;
        cand  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr_i) + i) % NUM_REQ;
            if (req_i[cand]) begin
                idx_o = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C write master; grant-to-enable latency 1 cycle.
// Requesters wait (hold i_req) until their o_ack; requests are not sampled outside IDLE.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDW         = 2,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 200000,
    parameter int TW          = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [DEV_W*NUM_REQ-1:0] i_dev_addr,
    input  logic [REG_W*NUM_REQ-1:0] i_data_addr,
    input  logic [DAT_W*NUM_REQ-1:0] i_wdata,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic [NUM_REQ-1:0]       o_err,
    output logic                     o_busy,
    output logic [IDW-1:0]           o_grant_id,
    output logic                     o_i2c_en,
    output logic [DEV_W-1:0]         o_device_addr,
    output logic [REG_W-1:0]         o_data_addr,
    output logic [DAT_W-1:0]         o_write_data,
    input  logic                     i_done_flag
);

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

    arb_state_e         state_q, state_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic               busy_q, busy_d;
    logic               en_q, en_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [DEV_W-1:0]   dev_q, dev_d;
    logic [REG_W-1:0]   reg_q, reg_d;
    logic [DAT_W-1:0]   dat_q, dat_d;

    logic               pick_vld;
    logic [IDW-1:0]     pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .vld_o   (pick_vld),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            dev_q   <= '0;
            reg_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        busy_d  = busy_q;
        en_d    = en_q;
        ack_d   = '0;
        err_d   = '0;
        dev_d   = dev_q;
        reg_d   = reg_q;
        dat_d   = dat_q;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    gid_d   = pick_idx;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    dev_d   = i_dev_addr[int'(pick_idx)*DEV_W +: DEV_W];
                    reg_d   = i_data_addr[int'(pick_idx)*REG_W +: REG_W];
                    dat_d   = i_wdata[int'(pick_idx)*DAT_W +: DAT_W];
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // Done takes priority when it lands on the timeout cycle.
                if (i_done_flag || cnt_q == TO_LAST) begin
                    state_d      = RESP;
                    en_d         = 1'b0;
                    ack_d[gid_q] = 1'b1;
                    err_d[gid_q] = ~i_done_flag;
                end
            end
            RESP: begin
                state_d = GAP;
                cnt_d   = '0;
                ptr_d   = (int'(gid_q) == NUM_REQ - 1) ? '0 : gid_q + IDW'(1);
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_ack         = ack_q;
    assign o_err         = err_q;
    assign o_busy        = busy_q;
    assign o_grant_id    = gid_q;
    assign o_i2c_en      = en_q;
    assign o_device_addr = dev_q;
    assign o_data_addr   = reg_q;
    assign o_write_data  = dat_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Randomized bench for i2c_master_arbiter against a transaction-level reference model.
module tb_i2c_master_arbiter;

    localparam int N   = 4;
    localparam int GAP = 16;
    localparam int TO  = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [6:0]    dev [N];
    logic [7:0]    rga [N];
    logic [7:0]    wd  [N];
    logic          done;

    logic [N-1:0]  o_ack, o_err;
    logic          o_busy, o_i2c_en;
    logic [1:0]    o_grant_id;
    logic [6:0]    o_device_addr;
    logic [7:0]    o_data_addr, o_write_data;
    logic [7*N-1:0] dev_bus;
    logic [8*N-1:0] rga_bus, wd_bus;

    int n_chk = 0;
    int n_err = 0;
    int m_ptr = 0;

    assign dev_bus = {dev[3], dev[2], dev[1], dev[0]};
    assign rga_bus = {rga[3], rga[2], rga[1], rga[0]};
    assign wd_bus  = {wd[3], wd[2], wd[1], wd[0]};

    always #5 clk = ~clk;

    i2c_master_arbiter #(
        .NUM_REQ     (N),
        .IDW         (2),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TO),
        .TW          (18)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (req),
        .i_dev_addr    (dev_bus),
        .i_data_addr   (rga_bus),
        .i_wdata       (wd_bus),
        .o_ack         (o_ack),
        .o_err         (o_err),
        .o_busy        (o_busy),
        .o_grant_id    (o_grant_id),
        .o_i2c_en      (o_i2c_en),
        .o_device_addr (o_device_addr),
        .o_data_addr   (o_data_addr),
        .o_write_data  (o_write_data),
        .i_done_flag   (done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic new_operands(input int k);
        dev[k] = 7'($urandom);
        rga[k] = 8'($urandom);
        wd[k]  = 8'($urandom);
    endtask

    // One transaction from IDLE; d = RUN cycle on which done is presented.
    task automatic do_txn(input int d, input bit rereq, output int g);
        int nh, cnt, exp_high;
        bit bad;
        logic [6:0] sd;
        logic [7:0] sr, sw;
        g  = model_pick(req, m_ptr);
        sd = dev[g];
        sr = rga[g];
        sw = wd[g];
        tick();
        chk("grant_en", 32'(o_i2c_en), 1);
        chk("grant_id", 32'(o_grant_id), 32'(g));
        chk("grant_busy", 32'(o_busy), 1);
        chk("grant_dev", 32'(o_device_addr), 32'(sd));
        chk("grant_reg", 32'(o_data_addr), 32'(sr));
        chk("grant_dat", 32'(o_write_data), 32'(sw));
        nh = 1;
        forever begin
            if (nh == d) done = 1'b1;
            if (nh == 5) begin
                wd[g] = ~wd[g];
                if ($urandom_range(0, 1) == 1) req[g] = 1'b0;
            end
            tick();
            done = 1'b0;
            if (!o_i2c_en || nh > TO + 5) break;
            nh++;
        end
        exp_high = (d <= TO) ? d : TO;
        chk("en_high_cycles", 32'(nh), 32'(exp_high));
        chk("ack", 32'(o_ack), 32'(1 << g));
        chk("err", 32'(o_err), (d > TO) ? 32'(1 << g) : 32'd0);
        chk("frozen_dat", 32'(o_write_data), 32'(sw));
        chk("frozen_dev", 32'(o_device_addr), 32'(sd));
        req[g] = 1'b0;
        m_ptr  = (g + 1) % N;
        cnt = 0;
        bad = 1'b0;
        forever begin
            if (cnt == 4) done = 1'b1;
            if (rereq && cnt == 3) begin
                req[g] = 1'b1;
                new_operands(g);
            end
            tick();
            done = 1'b0;
            cnt++;
            if (o_ack != 0 || o_i2c_en) bad = 1'b1;
            if (!o_busy || cnt > 60) break;
        end
        chk("gap_cycles", 32'(cnt), 32'(GAP + 1));
        chk("gap_quiet", 32'(bad), 0);
        chk("gid_hold", 32'(o_grant_id), 32'(g));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, d, r;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        for (int k = 0; k < N; k++) new_operands(k);
        tick();
        tick();
        chk("rst_en", 32'(o_i2c_en), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_ack", 32'(o_ack), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_gid", 32'(o_grant_id), 0);
        chk("rst_dev", 32'(o_device_addr), 0);
        chk("rst_reg", 32'(o_data_addr), 0);
        chk("rst_dat", 32'(o_write_data), 0);
        rst_n = 1'b1;

        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("idle_stray_en", 32'(o_i2c_en), 0);
        chk("idle_stray_ack", 32'(o_ack), 0);
        chk("idle_stray_busy", 32'(o_busy), 0);

        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_txn($urandom_range(1, 30), i < 4, g);
            chk("rr_order", 32'(g), 32'(i % N));
        end
        req = '0;
        tick();

        req    = 4'b0001;
        dev[0] = 7'h50;
        rga[0] = 8'h10;
        wd[0]  = 8'hA5;
        do_txn(60, 1'b0, g);

        req = 4'b0100;
        new_operands(2);
        do_txn(1_000_000, 1'b0, g);

        req = 4'b0010;
        new_operands(1);
        do_txn(TO, 1'b0, g);

        req = 4'b0100;
        new_operands(2);
        tick();
        chk("pre_rst_en", 32'(o_i2c_en), 1);
        repeat (49) tick();
        rst_n = 1'b0;
        tick();
        chk("midrun_rst_en", 32'(o_i2c_en), 0);
        chk("midrun_rst_busy", 32'(o_busy), 0);
        chk("midrun_rst_ack", 32'(o_ack), 0);
        rst_n = 1'b1;
        m_ptr = 0;
        req   = 4'b1001;
        new_operands(0);
        new_operands(3);
        do_txn($urandom_range(1, 40), 1'b0, g);
        chk("post_rst_ptr", 32'(g), 0);

        for (int rnd = 0; rnd < 30; rnd++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    req[k] = 1'b1;
                    new_operands(k);
                end
            end
            if (req == 0) begin
                r = $urandom_range(0, N - 1);
                req[r] = 1'b1;
                new_operands(r);
            end
            r = $urandom_range(0, 9);
            if (r == 0)      d = TO;
            else if (r == 1) d = TO + 20;
            else             d = $urandom_range(1, 40);
            do_txn(d, 1'b0, g);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
